// File: rtl/store_queue.sv
// store_queue: in-order store buffer that holds executed stores until retirement,
// forwards their data to younger loads and drains committed stores to memory.
module store_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alloc_en,
    input  logic [31:0]              alloc_addr,
    input  logic [31:0]              alloc_data,
    input  logic [1:0]               alloc_size,
    input  logic [TAG_W-1:0]         alloc_tag,
    input  logic                     commit_en,
    input  logic                     flush,
    output logic                     mem_we,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    input  logic                     mem_ready,
    input  logic                     ld_en,
    input  logic [31:0]              ld_addr,
    input  logic [1:0]               ld_size,
    output logic                     fwd_hit,
    output logic [31:0]              fwd_data,
    output logic                     fwd_stall,
    output logic                     full_SQ,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]        head, cptr, tail, cptr_n, idx;
    logic [29:0]        word_q [DEPTH];
    logic [3:0]         mask_q [DEPTH];
    logic [31:0]        data_q [DEPTH];
    logic [TAG_W-1:0]   tag_unused [DEPTH];
    logic               alloc_ok, commit_ok, drain_ok, found;
    logic [3:0]         ld_mask, sel_mask;
    logic [31:0]        sel_data;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
        return size == 2'b00 ? 4'b0001 << a : size == 2'b01 ? 4'b0011 << a : 4'b1111;
    endfunction

    assign count     = tail - head;
    assign full_SQ   = count == (AW+1)'(DEPTH);
    assign empty     = count == '0;
    assign mem_we    = head != cptr;
    assign mem_addr  = mem_we ? {word_q[head[AW-1:0]], 2'b00} : '0;
    assign mem_wdata = mem_we ? data_q[head[AW-1:0]] : '0;
    assign mem_be    = mem_we ? mask_q[head[AW-1:0]] : '0;
    assign alloc_ok  = alloc_en && !full_SQ && !flush;
    assign commit_ok = commit_en && cptr != tail;
    assign drain_ok  = mem_we && mem_ready;
    assign cptr_n    = cptr + (AW+1)'(commit_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            cptr <= '0;
            tail <= '0;
        end else begin
            head <= head + (AW+1)'(drain_ok);
            cptr <= cptr_n;
            tail <= flush ? cptr_n : tail + (AW+1)'(alloc_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_ok) begin
            word_q[tail[AW-1:0]]     <= alloc_addr[31:2];
            mask_q[tail[AW-1:0]]     <= lane_mask(alloc_size, alloc_addr[1:0]);
            data_q[tail[AW-1:0]]     <= alloc_data << {alloc_addr[1:0], 3'b000};
            tag_unused[tail[AW-1:0]] <= alloc_tag;
        end
    end

    // Scan oldest to youngest so the last overlapping match wins.
    always_comb begin
        ld_mask  = lane_mask(ld_size, ld_addr[1:0]);
        found    = 1'b0;
        sel_mask = '0;
        sel_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + (AW+1)'(i);
            if (ld_en && i < int'(count) && word_q[idx[AW-1:0]] == ld_addr[31:2]
                && |(mask_q[idx[AW-1:0]] & ld_mask)) begin
                found    = 1'b1;
                sel_mask = mask_q[idx[AW-1:0]];
                sel_data = data_q[idx[AW-1:0]];
            end
        end
        fwd_hit   = found && (ld_mask & ~sel_mask) == 4'b0000;
        fwd_stall = found && !fwd_hit;
        fwd_data  = fwd_hit ? sel_data : '0;
    end
endmodule

// File: doc/store_queue.md
# store_queue

In-order store queue between execute and data memory. It buffers executed stores until the reorder buffer retires them, then drains retired stores to data memory one per accepted handshake. It forwards buffered store data to younger loads and squashes wrong-path stores on flush. It drives `full_SQ`, which the hazard unit uses to stall fetch and decode.

## Interface
Parameters:
- DEPTH, 4, entry count; power of two, ≥2
- TAG_W, 4, ROB tag width stored per entry for debug/trace

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- alloc_en  in  1  execute-stage store valid; allocate at tail
- alloc_addr  in  32  store byte address
- alloc_data  in  32  rs2 value, unshifted
- alloc_size  in  2  funct3[1:0]: 00 SB, 01 SH, 10 SW
- alloc_tag  in  TAG_W  ROB tag of the store
- commit_en  in  1  ROB retires the oldest uncommitted store
- flush  in  1  squash all uncommitted entries
- mem_we  out  1  committed head entry is presented to memory
- mem_addr  out  32  head word address, {addr[31:2],2'b00}
- mem_wdata  out  32  head lane-aligned data
- mem_be  out  4  head byte enables
- mem_ready  in  1  memory accepts the head store this cycle
- ld_en  in  1  load lookup valid
- ld_addr  in  32  load byte address
- ld_size  in  2  funct3[1:0] of the load
- fwd_hit  out  1  youngest overlapping store fully covers the load
- fwd_data  out  32  that store's lane-aligned word
- fwd_stall  out  1  youngest overlapping store only partially covers the load
- full_SQ  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Circular buffer with three pointers, each with an extra wrap bit: head (oldest), cptr (oldest uncommitted), tail (next free). Invariant: head ≤ cptr ≤ tail in age order.
- Entry fields: word address, mask[3:0], data[31:0], tag.
  - Byte lane a = addr[1:0].
  - Masks: SB 4'b0001<<a; SH 4'b0011<<a; SW 4'b1111.
  - Lane data = alloc_data << 8*a.
  - Misaligned SH/SW are not checked; upstream traps them.
- Alloc: on alloc_en && !full_SQ && !flush, write the entry at tail and increment tail. alloc_en while full is dropped; the hazard unit guarantees no new store arrives.
- Commit: on commit_en && cptr != tail, increment cptr. commit_en with no uncommitted entry is ignored.
- Drain: mem_we = (head != cptr). mem_addr, mem_be and mem_wdata come from the head entry. When mem_we && mem_ready, increment head.
- Flush: tail <= cptr, after that cycle's commit is applied; a same-cycle commit survives. A same-cycle alloc is dropped. A same-cycle drain proceeds.
- Forwarding, combinational, only when ld_en:
  - ld_mask is built from ld_size and ld_addr[1:0], same rule as the store masks.
  - Scan all occupied entries, head through tail-1. Pick the youngest with a matching word address and (mask & ld_mask) != 0.
  - If (ld_mask & ~mask) == 0: fwd_hit=1 and fwd_data = entry data.
  - Otherwise: fwd_stall=1 and fwd_hit=0.
  - No match, or ld_en=0: both 0 and fwd_data=0.
- Committed entries are never squashed and still forward until they drain.

## Timing
- Reset values: head=cptr=tail=0, count=0, empty=1, full_SQ=0, mem_we=0, fwd_hit=0, fwd_stall=0, mem_*/fwd_data=0. Entry contents are don't-care.
- full_SQ, empty, count and mem_* depend only on registers; there is no combinational path from any input.
- fwd_* is same-cycle combinational from ld_* and registers. An entry allocated this cycle is not visible until the next cycle.
- Alloc-to-forward latency: 1 cycle. Commit-to-mem_we latency: 1 cycle. One drain per cycle maximum.
- Same cycle at full: a drain does not enable an alloc. full_SQ drops the cycle after the drain.
- All pointer arithmetic is mod 2·DEPTH. count = tail − head.

## Test plan
- Fill and drain:
  - 4 SW allocs (0x100..0x10C) -> full_SQ=1, count=4.
  - 5th alloc -> dropped.
  - 4 commits, then mem_ready=1 -> mem_we for 4 cycles, addresses 0x100..0x10C in order; empty=1 after.
- Flush mid-stream: allocate 3 stores, commit 1, assert flush with a same-cycle commit and alloc -> count=2, alloc dropped, cptr=tail.
- Full forward: SW 0x200 data 0xDEADBEEF, then LB at 0x203 -> fwd_hit=1, fwd_data=0xDEADBEEF.
- Youngest wins and partial stall:
  - SW 0x300=0x11111111 followed by SB 0x301=0xAA; LBU 0x301 -> fwd_hit, fwd_data=0x0000AA00.
  - LW 0x300 -> fwd_stall=1, fwd_hit=0.
- Backpressure: 2 committed entries with mem_ready=0 for 5 cycles -> mem_we=1 and head entry held stable; then mem_ready=1 -> 2 drains in 2 cycles.
- Reset mid-drain: assert rst_n=0 asynchronously while mem_we=1 -> all outputs at reset values immediately; no mem_we after release.
